pipe_skid_reg: RTL

- Generic, parametrised pipeline-stage register for the 5-stage MIPS32 core.
- Successor to the fixed-field inter-stage registers (F/D, D/E, E/M, M/W). Carries an opaque DATA_W payload with a valid/ready handshake, stall back-pressure and flush.
- A 2-entry skid buffer keeps in_ready purely registered, so stall does not form a combinational path across stages.
- Used between any two stages. The payload is the packed stage bundle, e.g. {ALURst, WD, A3, Instr, PCplus8}.

---
 rtl/pipe_skid_if.sv | 19 +
 rtl/pipe_skid_reg.sv | 73 +++++++
 2 files changed

// File: rtl/pipe_skid_if.sv
// pipe_skid_if: valid/ready handshake bundle for one pipeline-stage register
interface pipe_skid_if #(parameter int DATA_W = 32);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry skid pipeline register with registered in_ready; PIPE_BUBBLE_ZERO_EN forces bubbles to RESET_DATA
module pipe_skid_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input logic       clk,
  input logic       reset,
  pipe_skid_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_v, skid_v, in_fire, out_fire, load_main, load_skid, pop_skid;
  // Valid bits are decoded from the state so skid-without-main cannot be encoded
  assign main_v        = state != EMPTY;
  assign skid_v        = state == FULL;
  assign bus.in_ready  = ~skid_v & ~reset;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = main_v & bus.out_ready;
  assign bus.out_valid = main_v;
  assign bus.occ       = {skid_v, main_v & ~skid_v};
`ifdef PIPE_BUBBLE_ZERO_EN
  assign bus.out_data  = main_v ? main_data : RESET_DATA;
`else
  assign bus.out_data  = main_data;
`endif
  always_ff @(posedge clk)
    if (reset) state <= EMPTY;
    else state <= state_n;
  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_fire;
        state_n   = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
        state_n   = (in_fire & ~out_fire) ? FULL : (out_fire & ~in_fire) ? EMPTY : ONE;
      end
      FULL: begin
        pop_skid = out_fire;
        state_n  = out_fire ? ONE : FULL;
      end
      default: state_n = EMPTY;
    endcase
    if (bus.flush) begin
      state_n   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      main_data <= RESET_DATA;
      skid_data <= RESET_DATA;
    end else begin
`ifdef PIPE_BUBBLE_ZERO_EN
      if (bus.flush) main_data <= RESET_DATA;
      else if (load_main) main_data <= bus.in_data;
      else if (pop_skid) main_data <= skid_data;
`else
      if (load_main) main_data <= bus.in_data;
      else if (pop_skid) main_data <= skid_data;
`endif
      if (load_skid) skid_data <= bus.in_data;
    end
endmodule
